// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision constants, field widths and the FSM
// state type for the sequential floating-point adder/subtractor.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Extended mantissa: hidden bit + MAN_W fraction + guard, round, sticky.
  localparam int EXT_W = MAN_W + 4;
  // One extra bit on top of EXT_W to catch the carry-out of an addition.
  localparam int SUM_W = EXT_W + 1;

  // First biased exponent that no longer encodes a finite number.
  localparam int EXP_INF = 2 * BIAS + 1;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  localparam logic [31:0]      QNAN        = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF     = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] bits;
    logic        ovf;
    logic        unf;
  } fp_out_t;

endpackage

// File: rtl/fp_normalize.sv
// fp_normalize: leading-zero count and left shift of an extended mantissa.
// Ports:
//   mant_in  - extended mantissa (hidden bit at the MSB position when normal)
//   lzc      - number of leading zeros of mant_in (EXT_W when mant_in is 0)
//   mant_out - mant_in shifted left by lzc, MSB set unless mant_in is 0
module fp_normalize
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] mant_in,
  output logic [4:0]       lzc,
  output logic [EXT_W-1:0] mant_out
);

  logic found;

  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!found && !mant_in[i]) lzc = lzc + 5'd1;
      else found = 1'b1;
    end
    mant_out = mant_in << lzc;
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract.
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Denormal inputs are flushed to zero; any Inf/NaN operand yields a quiet NaN.
// Build option: define FP_ADDSUB_RNE_EN for round-to-nearest-even;
// otherwise results are truncated and no sticky logic is built.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only in IDLE)
//   op_a, op_b, sub     - operands; sub=1 computes op_a - op_b
//   out_valid/out_ready - result handshake (valid only in DONE)
//   result, ovf, unf    - packed result, overflow-to-inf, flush-to-zero flags
//   busy                - operation in progress (state is not IDLE)
module fp_addsub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        busy
);

  // Signed exponent wide enough for exp+2 and exp-EXT_W.
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_INF_S = XW'(EXP_INF);

  state_t state, state_nxt;

  logic [31:0]             a_p0, b_p0;
  logic                    sub_p0;
  logic [EXP_W-1:0]        exp_p1;
  logic [EXT_W-1:0]        man_l_p1, man_s_p1;
  logic                    eff_sub_p1, sign_p1, nan_p1;
  logic [SUM_W-1:0]        sum_p2;
  logic [EXP_W-1:0]        exp_p2;
  logic                    sign_p2, nan_p2;
  logic [EXT_W-1:0]        man_p3;
  logic signed [XW-1:0]    exp_p3;
  logic                    sign_p3, nan_p3, zero_p3;

`ifdef FP_ADDSUB_RNE_EN
  function automatic logic [MAN_W+1:0] round_man(input logic [MAN_W:0] m,
                                                  input logic [2:0] grs);
    logic inc;
    // Round up above half, or on an exact half when the LSB is odd.
    inc = grs[2] & (grs[1] | grs[0] | m[0]);
    return {1'b0, m} + {{(MAN_W+1){1'b0}}, inc};
  endfunction
`else
  function automatic logic [MAN_W+1:0] round_man(input logic [MAN_W:0] m);
    return {1'b0, m};
  endfunction
`endif

  function automatic fp_out_t saturate(input logic sign,
                                       input logic signed [XW-1:0] e,
                                       input logic [MAN_W-1:0] frac);
    fp_out_t o;
    o = '0;
    if (e >= EXP_INF_S) begin
      o.bits = {sign, POS_INF[30:0]};
      o.ovf  = 1'b1;
    end else if (e <= $signed(XW'(0))) begin
      o.bits = {sign, 31'd0};
      o.unf  = 1'b1;
    end else begin
      o.bits = {sign, e[EXP_W-1:0], frac};
    end
    return o;
  endfunction

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ALIGN;
      end
      ALIGN: state_nxt = ADD;
      ADD:   state_nxt = NORM;
      NORM:  state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALIGN: unpack, order by magnitude, shift the smaller operand
  logic [EXP_W-1:0] ea_c, eb_c, el_c, es_c, diff_c;
  logic [MAN_W:0]   ma_c, mb_c, ml_c, ms_c;
  logic [EXT_W-1:0] ms_ext_c, ms_sh_c;
  logic             swap_c, sign_l_c, nan_c;
`ifdef FP_ADDSUB_RNE_EN
  logic             sticky_c;
`endif

  always_comb begin
    ea_c  = a_p0[30:23];
    eb_c  = b_p0[30:23];
    nan_c = (ea_c == EXP_SPECIAL) || (eb_c == EXP_SPECIAL);
    ma_c  = (ea_c != '0) ? {1'b1, a_p0[MAN_W-1:0]} : '0;
    mb_c  = (eb_c != '0) ? {1'b1, b_p0[MAN_W-1:0]} : '0;
    // Ordering by full magnitude keeps the difference non-negative.
    swap_c = {eb_c, mb_c[MAN_W-1:0]} > {ea_c, ma_c[MAN_W-1:0]};
    if (swap_c) begin
      el_c = eb_c; es_c = ea_c; ml_c = mb_c; ms_c = ma_c;
      sign_l_c = b_p0[31] ^ sub_p0;
    end else begin
      el_c = ea_c; es_c = eb_c; ml_c = ma_c; ms_c = mb_c;
      sign_l_c = a_p0[31];
    end
    diff_c   = el_c - es_c;
    ms_ext_c = {ms_c, 3'b000};
    if (diff_c >= 8'd27) ms_sh_c = '0;
    else                 ms_sh_c = ms_ext_c >> diff_c;
`ifdef FP_ADDSUB_RNE_EN
    if (diff_c >= 8'd27) sticky_c = |ms_c;
    else sticky_c = |(ms_ext_c & ((EXT_W'(1) << diff_c) - EXT_W'(1)));
    ms_sh_c[0] = ms_sh_c[0] | sticky_c;
`endif
  end

  // ADD: effective add or subtract of the aligned mantissas
  logic [SUM_W-1:0] sum_c;

  always_comb begin
    if (eff_sub_p1) sum_c = {1'b0, man_l_p1} - {1'b0, man_s_p1};
    else            sum_c = {1'b0, man_l_p1} + {1'b0, man_s_p1};
  end

  // NORM: one-cycle normalization (carry right-shift or LZC left-shift)
  logic [4:0]           lzc_c;
  logic [EXT_W-1:0]     norm_c, man_n_c;
  logic signed [XW-1:0] exp_n_c;

  fp_normalize u_norm (
    .mant_in  (sum_p2[EXT_W-1:0]),
    .lzc      (lzc_c),
    .mant_out (norm_c)
  );

  always_comb begin
    if (sum_p2[SUM_W-1]) begin
`ifdef FP_ADDSUB_RNE_EN
      man_n_c = {sum_p2[SUM_W-1:2], sum_p2[1] | sum_p2[0]};
`else
      man_n_c = sum_p2[SUM_W-1:1];
`endif
      exp_n_c = $signed({2'b00, exp_p2}) + $signed(XW'(1));
    end else begin
      man_n_c = norm_c;
      exp_n_c = $signed({2'b00, exp_p2}) - $signed({5'b00000, lzc_c});
    end
  end

  // ROUND: round, renormalize on carry, pack with overflow/underflow
  logic [MAN_W+1:0]     rnd_c;
  logic signed [XW-1:0] exp_r_c;
  logic [MAN_W-1:0]     frac_c;
  fp_out_t              out_c;
  logic                 unused_bits;

  always_comb begin
`ifdef FP_ADDSUB_RNE_EN
    rnd_c = round_man(man_p3[EXT_W-1:3], man_p3[2:0]);
`else
    rnd_c = round_man(man_p3[EXT_W-1:3]);
`endif
    // A rounding carry leaves exactly 1.0 x 2^(e+1).
    exp_r_c = exp_p3 + (rnd_c[MAN_W+1] ? $signed(XW'(1)) : $signed(XW'(0)));
    frac_c  = rnd_c[MAN_W+1] ? '0 : rnd_c[MAN_W-1:0];
    if (nan_p3) begin
      out_c      = '0;
      out_c.bits = QNAN;
    end else if (zero_p3) begin
      out_c = '0;
    end else begin
      out_c = saturate(sign_p3, exp_r_c, frac_c);
    end
  end

`ifdef FP_ADDSUB_RNE_EN
  assign unused_bits = rnd_c[MAN_W];
`else
  assign unused_bits = ^{rnd_c[MAN_W], man_p3[2:0]};
`endif

  // Datapath registers: each stage loads only while its state is active.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_p0   <= op_a;
          b_p0   <= op_b;
          sub_p0 <= sub;
        end
      end
      ALIGN: begin
        exp_p1     <= el_c;
        man_l_p1   <= {ml_c, 3'b000};
        man_s_p1   <= ms_sh_c;
        eff_sub_p1 <= sub_p0 ^ a_p0[31] ^ b_p0[31];
        sign_p1    <= sign_l_c;
        nan_p1     <= nan_c;
      end
      ADD: begin
        sum_p2  <= sum_c;
        exp_p2  <= exp_p1;
        sign_p2 <= (sum_c == '0) ? 1'b0 : sign_p1;
        nan_p2  <= nan_p1;
      end
      NORM: begin
        man_p3  <= man_n_c;
        exp_p3  <= exp_n_c;
        sign_p3 <= sign_p2;
        zero_p3 <= (sum_p2 == '0);
        nan_p3  <= nan_p2;
      end
      default: ;
    endcase
  end

  // Result registers: visible outputs, so they are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (state == ROUND) begin
      result <= out_c.bits;
      ovf    <= out_c.ovf;
      unf    <= out_c.unf;
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: scoreboard bench for fp_addsub_seq. Directed cases,
// output stall, mid-operation reset and randomized operands checked against
// a reference model built from plain integer arithmetic.
// Honors FP_ADDSUB_RNE_EN the same way the design does.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        in_ready, out_valid, ovf, unf, busy;
  logic [31:0] result;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          acc;
  } sb_t;

  sb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: B is placed on A's grid with three extra bits below the LSB;
  // RNE keeps a sticky bit for everything shifted out, truncation drops it.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] res, output logic ovf_o,
                                    output logic unf_o);
    longint ma, mb, ml, ms, lv, sv, sum, m24;
    int     ea, eb, el, es, d, e;
    logic   sl, effsub;
`ifdef FP_ADDSUB_RNE_EN
    logic   stk;
    longint lo;
`endif
    res = 32'd0; ovf_o = 1'b0; unf_o = 1'b0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      res = 32'h7FC0_0000;
      return;
    end
    ma = (ea != 0) ? (longint'(1) << 23) + longint'(a[22:0]) : 0;
    mb = (eb != 0) ? (longint'(1) << 23) + longint'(b[22:0]) : 0;
    if (eb > ea || (eb == ea && mb > ma)) begin
      el = eb; es = ea; ml = mb; ms = ma; sl = b[31] ^ s;
    end else begin
      el = ea; es = eb; ml = ma; ms = mb; sl = a[31];
    end
    d  = el - es;
    lv = ml * 8;
    if (d >= 27) sv = 0;
    else         sv = (ms * 8) >> d;
`ifdef FP_ADDSUB_RNE_EN
    if (d >= 27) stk = (ms != 0);
    else         stk = ((sv << d) != ms * 8);
    if (stk) sv = sv | 1;
`endif
    effsub = s ^ a[31] ^ b[31];
    sum = effsub ? lv - sv : lv + sv;
    if (sum == 0) return;
    e = el;
    if (sum >= (longint'(1) << 27)) begin
`ifdef FP_ADDSUB_RNE_EN
      lo  = sum & 1;
      sum = (sum >> 1) | lo;
`else
      sum = sum >> 1;
`endif
      e = e + 1;
    end else begin
      while (sum < (longint'(1) << 26)) begin
        sum = sum << 1;
        e = e - 1;
      end
    end
    m24 = sum >> 3;
`ifdef FP_ADDSUB_RNE_EN
    if (((sum >> 2) & 1) == 1 && ((sum & 3) != 0 || (m24 & 1) == 1)) m24 = m24 + 1;
    if (m24 == (longint'(1) << 24)) begin
      m24 = m24 >> 1;
      e = e + 1;
    end
`endif
    if (e >= 255) begin
      res = {sl, 8'hFF, 23'd0};
      ovf_o = 1'b1;
    end else if (e <= 0) begin
      res = {sl, 31'd0};
      unf_o = 1'b1;
    end else begin
      res = {sl, e[7:0], m24[22:0]};
    end
  endfunction

  // Monitor: every DONE cycle is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out: result %h with nothing expected", result);
      end else begin
        if (!seen) begin
          // DONE is the fifth cycle after the accept edge (ALIGN is the first).
          check("latency", 32'(cyc - exp_q[0].acc + 1), 32'd5);
          seen = 1'b1;
        end
        check("result", result, exp_q[0].res);
        check("ovf", {31'd0, ovf}, {31'd0, exp_q[0].ovf});
        check("unf", {31'd0, unf}, {31'd0, exp_q[0].unf});
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] er, input logic eo, input logic eu);
    sb_t t;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t.res = er; t.ovf = eo; t.unf = eu; t.acc = cyc;
    exp_q.push_back(t);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] er, input logic eo, input logic eu);
    int g = 0;
    @(posedge clk);
    #1;
    while (!in_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready %b required 1", in_ready);
      return;
    end
    issue(a, b, s, er, eo, eu);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, r, rne_exp;
    logic        s, o, u;
    int          g;

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_unf", {31'd0, unf}, 32'd0);

    // Release reset and present an operand for the very next edge.
    rst = 1'b0;
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    wait_drain();

`ifdef FP_ADDSUB_RNE_EN
    rne_exp = 32'h3F80_0002;
`else
    rne_exp = 32'h3F80_0001;
`endif
    send(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    send(32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'hFF80_0000, 1'b1, 1'b0);
    send(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    send(32'h3F80_0001, 32'h3380_0000, 1'b0, rne_exp, 1'b0, 1'b0);
    send(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    send(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);
    send(32'h3F80_0000, 32'hFFC0_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    wait_drain();

    // Stall the consumer in DONE while another operand is offered.
    out_ready = 1'b0;
    send(32'h40A0_0000, 32'h3F80_0000, 1'b0, 32'h40C0_0000, 1'b0, 1'b0);
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handshake_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("ignored_input_idle", {31'd0, busy}, 32'd0);
    check("held_result_kept", result, 32'h40C0_0000);

    // Reset while the operation sits in NORM.
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_unf", {31'd0, unf}, 32'd0);
    exp_q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom;
        1: b = {1'($urandom), 8'(a[30:23] + 8'($urandom_range(0, 6)) - 8'd3), 23'($urandom)};
        2: b = a ^ 32'h8000_0000;
        3: b = {a[31:23], 23'($urandom)};
        4: b = {1'($urandom), 8'hFF, 23'($urandom)};
        default: begin
          a = {1'($urandom), 8'($urandom_range(1, 4)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
        end
      endcase
      s = 1'($urandom);
      ref_model(a, b, s, r, o, u);
      send(a, b, s, r, o, u);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
